// File: rtl/mux_scan_if.sv
// Bundle of the sequencer's scan-request, mux and downstream byte signals.
// master: the sequencer. slave: the environment (requester, mux and consumer).
// Handshake: a byte is transferred on a rising clk edge where data_valid and
// data_ready are both 1. data_out and data_valid stay stable while data_valid=1
// and data_ready=0. data_valid does not depend combinationally on data_ready.
interface mux_scan_if;
   logic       start;
   logic [7:0] chan_mask;
   logic [2:0] sel;
   logic       y_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       busy;

   modport master (
      input  start, chan_mask, y_in, data_ready,
      output sel, data_out, data_valid, busy
   );

   modport slave (
      output start, chan_mask, y_in, data_ready,
      input  sel, data_out, data_valid, busy
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 single-bit mux. Walks the enabled channels in
// ascending order, holds each select for DWELL cycles, then samples y_in.
// The eight samples are assembled into one byte and offered on a valid/ready
// port. state_dbg exposes the FSM state (0=IDLE, 1=SCAN, 2=DONE).
module mux_scan_sequencer #(
   parameter int DWELL = 2,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   mux_scan_if.master bus,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       mask_q, mask_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic             has_next;
   logic [2:0]       next_ch;
   logic [2:0]       first_ch;

   // Lowest enabled channel strictly above the current select (no wrap).
   always_comb begin
      has_next = 1'b0;
      next_ch  = sel_q;
      for (int i = 7; i >= 0; i--) begin
         if ((i > int'(sel_q)) && mask_q[i]) begin
            has_next = 1'b1;
            next_ch  = 3'(i);
         end
      end
   end

   // Lowest enabled channel in the incoming request mask.
   always_comb begin
      first_ch = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bus.chan_mask[i]) first_ch = 3'(i);
      end
   end

   // Next-state and datapath update for the scan FSM.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      mask_d  = mask_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mask_d = bus.chan_mask;
               data_d = 8'd0;
               busy_d = 1'b1;
               cnt_d  = '0;
               if (bus.chan_mask != 8'd0) begin
                  sel_d   = first_ch;
                  state_d = SCAN;
               end else begin
                  valid_d = 1'b1;
                  state_d = DONE;
               end
            end
         end
         SCAN: begin
            if (cnt_q == LAST_CNT) begin
               data_d[sel_q] = bus.y_in;
               cnt_d         = '0;
               if (has_next) begin
                  sel_d = next_ch;
               end else begin
                  valid_d = 1'b1;
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (valid_q && bus.data_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any scan or pending byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         cnt_q   <= '0;
         data_q  <= 8'd0;
         mask_q  <= 8'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.busy       = busy_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural 8:1 mux drives y_in, and each
// scan is predicted from the mask and mux inputs (visited channels, hold time,
// valid latency, captured byte = mask & inputs).
module tb_mux_scan_sequencer;
   localparam int DWELL = 2;

   logic       clk;
   logic       rst;
   logic [1:0] state_dbg;
   logic [7:0] mux_in;
   int         cmp_cnt;
   int         err_cnt;
   int         last_sel;

   mux_scan_if bus ();

   mux_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Behavioural 8:1 mux stage.
   assign bus.y_in = mux_in[bus.sel];

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "time limit reached");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one scan and handshake, predicting every cycle from the mask rules.
   task automatic run_scan(input logic [7:0] mask, input logic [7:0] din, input int bp);
      int         chans[$];
      logic [7:0] exp_data;
      logic [7:0] held_data;
      int         n;
      for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
      n        = chans.size();
      exp_data = mask & din;
      mux_in   = din;
      bus.chan_mask = mask;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.chan_mask = 8'($urandom);
      check("busy_after_start", bus.busy, 1);
      if (n == 0) begin
         check("zero_mask_sel", bus.sel, last_sel);
      end else begin
         for (int j = 0; j < n * DWELL; j++) begin
            check("scan_sel", bus.sel, chans[j / DWELL]);
            check("scan_valid_low", bus.data_valid, 0);
            check("scan_busy", bus.busy, 1);
            tick();
         end
         last_sel = chans[n - 1];
      end
      check("valid_rise", bus.data_valid, 1);
      check("data_out", bus.data_out, exp_data);
      held_data = exp_data;
      for (int k = 0; k < bp; k++) begin
         bus.start = 1'($urandom_range(0, 1));
         tick();
         check("bp_valid", bus.data_valid, 1);
         check("bp_data", bus.data_out, held_data);
         check("bp_busy", bus.busy, 1);
         check("bp_sel", bus.sel, last_sel);
      end
      bus.data_ready = 1'b1;
      bus.start      = 1'b1;
      tick();
      bus.data_ready = 1'b0;
      bus.start      = 1'b0;
      check("xfer_valid_low", bus.data_valid, 0);
      check("xfer_busy_low", bus.busy, 0);
      check("xfer_sel_hold", bus.sel, last_sel);
   endtask

   initial begin
      cmp_cnt        = 0;
      err_cnt        = 0;
      last_sel       = 0;
      mux_in         = 8'h00;
      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.chan_mask  = 8'h00;
      bus.data_ready = 1'b0;

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_sel", bus.sel, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_valid", bus.data_valid, 0);
      check("rst_busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Idle without start.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_busy", bus.busy, 0);
         check("idle_valid", bus.data_valid, 0);
         check("idle_sel", bus.sel, 0);
      end

      // Directed scans.
      run_scan(8'hFF, 8'hA5, 0);
      run_scan(8'b1000_0101, 8'hFF, 0);
      last_sel = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      run_scan(8'h00, 8'hFF, 0);
      run_scan(8'h3C, 8'h96, 10);
      // New start accepted straight after a transfer.
      run_scan(8'h81, 8'hC3, 1);

      // Abort mid-scan at sel=3, then a clean scan.
      mux_in        = 8'h5A;
      bus.chan_mask = 8'hFF;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.sel == 3'd3) break;
         tick();
      end
      check("abort_reach_sel3", bus.sel, 3);
      #3 rst = 1'b1;
      #1;
      check("abort_sel", bus.sel, 0);
      check("abort_data", bus.data_out, 0);
      check("abort_valid", bus.data_valid, 0);
      check("abort_busy", bus.busy, 0);
      #2 rst = 1'b0;
      last_sel = 0;
      tick();
      check("post_abort_idle", bus.busy, 0);
      run_scan(8'hFF, 8'h3C, 2);

      // Randomised scans.
      for (int t = 0; t < 12; t++) begin
         logic [7:0] m;
         m = (t % 5 == 4) ? 8'h00 : 8'($urandom);
         run_scan(m, 8'($urandom), $urandom_range(0, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 8:1 single-bit mux stage. Drives its 3-bit select and samples its output.
- On a start pulse it walks the enabled channels in ascending order, holding each select value for a programmable dwell time.
- It samples the mux output once per enabled channel and assembles the eight results into a byte.
- The byte is delivered downstream over a valid/ready handshake.

Parameters:
- DWELL, default 2: cycles each select value is held before the mux output is sampled. Legal range 1..255.
- CNT_W, default 8: width of the internal dwell counter. Must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a scan. Honoured only in IDLE; ignored in every other state.
- chan_mask  input  8  per-channel enable, bit n = channel n. Latched on the cycle start is accepted.
- sel  output  3  registered select, driven to the mux SEL input.
- y_in  input  1  mux output Y, sampled by this block.
- data_out  output  8  captured byte; bit n = sampled value of channel n.
- data_valid  output  1  data_out is valid.
- data_ready  input  1  downstream accepts data_out.
- busy  output  1  high from accepted start until the handshake completes.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, sel=0, data_out=0, data_valid=0, busy=0, dwell counter=0, latched mask=0. Asserting rst mid-scan or mid-handshake aborts immediately and discards partial data.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at a rising edge → latch chan_mask, clear data_out, busy=1.
  - If the latched mask != 0: sel=lowest enabled channel, counter=0, go to SCAN.
  - If chan_mask=0: go directly to DONE, data_out=0, data_valid=1 (one cycle after start).
- SCAN:
  - sel is held stable; the counter increments each cycle.
  - At the edge where counter==DWELL-1: data_out[sel] <= y_in, counter <= 0.
  - If a higher enabled channel exists, sel <= the lowest enabled channel above the current sel (next-enabled search is combinational, ascending, no wrap).
  - Otherwise go to DONE and set data_valid=1 on that same edge.
- Disabled channels are never selected, and their data_out bits stay 0.
- Latency: data_valid rises N*DWELL cycles after the start edge, where N = popcount(mask).
- DONE:
  - data_out and data_valid are held stable until data_ready=1.
  - On the edge where data_valid && data_ready: data_valid=0, busy=0, go to IDLE. sel holds its last value.
  - start asserted in the handshake cycle is ignored. The earliest new accept is the following cycle.
- chan_mask changes after acceptance have no effect on the current scan.
- y_in is assumed stable relative to sel. The block adds no synchroniser.

Test Plan:
- Reset then idle: rst pulse mid-clock → all outputs 0 asynchronously. No activity without start; busy=0.
- Full scan: DWELL=2, mask=8'hFF, mux inputs I=8'hA5 (bench mux instance), start 1 cycle.
  - Required: sel steps 0..7, each held 2 cycles.
  - Required: data_valid at +16 cycles, data_out=8'hA5.
- Sparse mask: mask=8'b1000_0101, I=8'hFF.
  - Required: sel visits only 0, 2, 7.
  - Required: data_valid at +6 cycles, data_out=8'h85.
- Zero mask: mask=0, start → data_valid the next cycle, data_out=0, sel stays 0.
- Backpressure: hold data_ready=0 for 10 cycles after valid.
  - Required: data_out and data_valid stable; start pulses ignored.
  - Required: on ready=1, one transfer, busy falls, and a new start is accepted the next cycle.
- Abort: assert rst during SCAN at sel=3 → immediate return to reset values. A subsequent scan runs cleanly with correct data.
